// File: rtl/mult_job_scheduler.sv
// Operand-pair FIFO feeding an external multi-cycle multiplier, one job at a time,
// with a single-entry result register that is never overwritten before it is drained.
module mult_job_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                 state_q, state_d;
    logic [2*WIDTH-1:0]     mem_q [DEPTH];
    logic [2*WIDTH-1:0]     mem_d [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WIDTH-1:0]       mul_a_q, mul_a_d;
    logic [WIDTH-1:0]       mul_b_q, mul_b_d;
    logic                   out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]     out_product_q, out_product_d;
    logic                   seen_low_q, seen_low_d;
    logic                   push, pop;

    always_comb begin
        state_d       = state_q;
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        seen_low_d    = seen_low_q;
        pop           = 1'b0;
        push          = in_valid && in_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && (!out_valid_q || out_ready)) begin
                    pop                = 1'b1;
                    {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
                    state_d            = StIssue;
                end
            end
            StIssue: begin
                // A done still held high from the previous job must drop before we trust it.
                seen_low_d = !mul_done;
                state_d    = StWait;
            end
            StWait: begin
                if (mul_done && seen_low_q) begin
                    out_product_d = mul_product;
                    out_valid_d   = 1'b1;
                    state_d       = StIdle;
                end else if (!mul_done) begin
                    seen_low_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {in_a, in_b};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            seen_low_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            seen_low_q    <= seen_low_d;
        end
    end

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign mul_start   = (state_q == StIssue);
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign count       = count_q;
    assign busy        = (state_q != StIdle);

endmodule
